// File: rtl/port_out_arb_pkg.sv
// Shared types and sizing helpers for the switch output-port drain arbiter.
package port_out_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CAPT = 2'd2,
        SEND = 2'd3
    } arb_state_e;

    localparam int BURST_CNT_W = 8;

    // Index width for a port count; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/port_out_arb_rr_arbiter.sv
// Combinational round-robin pick: first requesting port after last_grant, wrapping.
module rr_arbiter
    import port_out_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last_grant,
    output logic [IDX_W-1:0]     o_grant,
    output logic                 o_grant_valid
);

    int w_idx;

    // Walk offsets 1..NUM_PORTS so the most recently served port has lowest priority.
    always_comb begin
        o_grant       = '0;
        o_grant_valid = 1'b0;
        w_idx         = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_idx         = (int'(i_last_grant) + k) % NUM_PORTS;
            o_grant       = (!o_grant_valid && i_req[w_idx]) ? IDX_W'(w_idx) : o_grant;
            o_grant_valid = o_grant_valid | i_req[w_idx];
        end
    end

endmodule

// File: rtl/port_out_arb.sv
// Drains NUM_PORTS switch output FIFOs into one stream, bursting up to BURST_LEN words per grant.
module port_out_arb
    import port_out_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int W_WIDTH   = 8,
    parameter  int BURST_LEN = 4,
    localparam int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arb_en,
    input  logic [NUM_PORTS-1:0]         port_rdy,
    input  logic [NUM_PORTS*W_WIDTH-1:0] port_out,
    output logic [NUM_PORTS-1:0]         port_rd,
    output logic [W_WIDTH-1:0]           out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_port,
    output logic                         busy
);

    localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(BURST_LEN);
    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_PORTS - 1);

    arb_state_e             r_state;
    arb_state_e             w_next_state;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       r_last_grant;
    logic [IDX_W-1:0]       w_arb_grant;
    logic [IDX_W-1:0]       w_sel_grant;
    logic                   w_arb_valid;
    logic                   w_continue;
    logic [BURST_CNT_W-1:0] r_burst_cnt;
    logic [NUM_PORTS-1:0]   r_port_rd;
    logic [NUM_PORTS-1:0]   w_port_rd_nxt;
    logic [W_WIDTH-1:0]     r_out_data;
    logic [W_WIDTH-1:0]     w_capt_word;
    logic                   r_out_valid;
    logic [IDX_W-1:0]       r_out_port;
    logic                   r_busy;

    rr_arbiter #(
        .NUM_PORTS(NUM_PORTS)
    ) u_rr_arbiter (
        .i_req        (port_rdy),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_grant_valid(w_arb_valid)
    );

    // Burst continues only while the granted FIFO still holds data, so no read hits an empty port.
    assign w_continue  = (r_burst_cnt < BURST_MAX) && port_rdy[r_grant] && arb_en;
    assign w_capt_word = port_out[int'(r_grant)*W_WIDTH +: W_WIDTH];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (arb_en && w_arb_valid) begin
                    w_next_state = READ;
                end else begin
                    w_next_state = IDLE;
                end
            end
            READ:    w_next_state = CAPT;
            CAPT:    w_next_state = SEND;
            SEND: begin
                if (out_ready) begin
                    w_next_state = w_continue ? READ : IDLE;
                end else begin
                    w_next_state = SEND;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode: the read strobe is registered, so it is computed for the state being entered
    always_comb begin
        w_sel_grant = (r_state == IDLE) ? w_arb_grant : r_grant;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_port_rd_nxt[i] = (w_next_state == READ) && (int'(w_sel_grant) == i);
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port_rd    <= '0;
            r_busy       <= 1'b0;
            r_grant      <= '0;
            r_last_grant <= LAST_IDX;
            r_burst_cnt  <= '0;
            r_out_data   <= '0;
            r_out_port   <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_port_rd <= w_port_rd_nxt;
            r_busy    <= (w_next_state != IDLE);
            if ((r_state == IDLE) && (w_next_state == READ)) begin
                r_grant     <= w_arb_grant;
                r_burst_cnt <= '0;
            end
            // Port read latency is one cycle: data requested in READ is present during CAPT.
            if (r_state == CAPT) begin
                r_out_data  <= w_capt_word;
                r_out_port  <= r_grant;
                r_out_valid <= 1'b1;
                r_burst_cnt <= r_burst_cnt + BURST_CNT_W'(1);
            end
            if ((r_state == SEND) && out_ready) begin
                r_out_valid <= 1'b0;
                if (w_next_state == IDLE) begin
                    r_last_grant <= r_grant;
                end
            end
        end
    end

    assign port_rd   = r_port_rd;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_port  = r_out_port;
    assign busy      = r_busy;

endmodule

// File: tb/tb_port_out_arb.sv
// Directed self-checking bench for port_out_arb with a FIFO/consumer model around the DUT.
module tb_port_out_arb;

    localparam int NP = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            arb_en;
    logic [NP-1:0]   port_rdy;
    logic [NP*W-1:0] port_out;
    logic [NP-1:0]   port_rd;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_port;
    logic            busy;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] mem [NP][64];
    int         wp [NP];
    int         rp [NP];
    int         rd_cnt [NP];
    logic [7:0] q_word [NP];
    logic [9:0] obs_q [$];
    int         obs_t [$];
    int         cyc = 0;
    bit         rd_multi_seen = 1'b0;
    bit         rd_empty_seen = 1'b0;
    logic       ld_en  = 1'b0;
    int         ld_port = 0;
    logic [7:0] ld_data = 8'h00;
    logic       tb_clr = 1'b0;

    always #5 clk = ~clk;

    port_out_arb #(.NUM_PORTS(NP), .W_WIDTH(W), .BURST_LEN(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arb_en   (arb_en),
        .port_rdy (port_rdy),
        .port_out (port_out),
        .port_rd  (port_rd),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_port (out_port),
        .busy     (busy)
    );

    // Port FIFOs with one-cycle read latency, plus a consumer log of every handshake.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ($countones(port_rd) > 1) rd_multi_seen <= 1'b1;
        for (int i = 0; i < NP; i++) begin
            if (port_rd[i]) begin
                if (wp[i] == rp[i]) rd_empty_seen <= 1'b1;
                q_word[i] <= mem[i][rp[i] % 64];
                rp[i]     <= rp[i] + 1;
                rd_cnt[i] <= rd_cnt[i] + 1;
            end
        end
        if (out_valid && out_ready) begin
            obs_q.push_back({out_port, out_data});
            obs_t.push_back(cyc);
        end
        if (ld_en) begin
            mem[ld_port][wp[ld_port] % 64] <= ld_data;
            wp[ld_port] <= wp[ld_port] + 1;
        end
        if (tb_clr) begin
            for (int i = 0; i < NP; i++) begin
                wp[i] <= 0;
                rp[i] <= 0;
                rd_cnt[i] <= 0;
            end
            obs_q.delete();
            obs_t.delete();
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            port_rdy[i]          = (wp[i] != rp[i]);
            port_out[i*W +: W]   = q_word[i];
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; arb_en = 1'b0; out_ready = 1'b0; ld_en = 1'b0; tb_clr = 1'b1;
        step(2);
        rst_n = 1'b1; tb_clr = 1'b0;
        step(1);
    endtask

    task automatic load(input int p, input logic [7:0] d);
        ld_en = 1'b1; ld_port = p; ld_data = d;
        step(1);
        ld_en = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            step(1);
            if (obs_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arb_en = 1'b1; out_ready = 1'b1; tb_clr = 1'b1; ld_en = 1'b0;
        step(2);
        vectors++; if (port_rd !== 4'b0000) begin errors++; $display("FAIL reset_port_rd: got %b want 0000", port_rd); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        vectors++; if (out_port !== 2'd0) begin errors++; $display("FAIL reset_out_port: got %0d want 0", out_port); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1; tb_clr = 1'b0; arb_en = 1'b0; out_ready = 1'b0;
        step(1);
    endtask

    task automatic test_single_word();
        do_reset();
        arb_en = 1'b1; out_ready = 1'b1;
        load(0, 8'hA5);
        step(1);
        vectors++; if (port_rd !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL single_read: port_rd=%b busy=%b want 0001/1", port_rd, busy); end
        step(1);
        vectors++; if (port_rd !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL single_capt: port_rd=%b out_valid=%b want 0000/0", port_rd, out_valid); end
        step(1);
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_port !== 2'd0) begin
            errors++; $display("FAIL single_send: valid=%b data=%h port=%0d want 1/a5/0", out_valid, out_data, out_port); end
        step(1);
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || obs_q.size() != 1) begin
            errors++; $display("FAIL single_done: valid=%b busy=%b words=%0d want 0/0/1", out_valid, busy, obs_q.size()); end
        vectors++; if (rd_cnt[0] != 1) begin errors++; $display("FAIL single_rd_count: got %0d want 1", rd_cnt[0]); end
    endtask

    task automatic test_burst_rotation();
        bit ok;
        int p, k;
        logic [9:0] exp_w;
        do_reset();
        for (int pp = 0; pp < NP; pp++)
            for (int kk = 0; kk < 10; kk++) load(pp, 8'(pp*16 + kk));
        arb_en = 1'b1; out_ready = 1'b1;
        wait_obs(20, 200, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL burst_timeout: got %0d words want 20", obs_q.size()); end
        for (int j = 0; j < 20 && j < obs_q.size(); j++) begin
            p = (j / 4) % 4;
            k = (j >= 16) ? 4 + (j % 4) : (j % 4);
            exp_w = {2'(p), 8'(p*16 + k)};
            vectors++; if (obs_q[j] !== exp_w) begin errors++; $display("FAIL burst_word%0d: got %h want %h", j, obs_q[j], exp_w); end
        end
        if (obs_t.size() >= 5) begin
            vectors++; if (obs_t[1] - obs_t[0] != 3) begin errors++; $display("FAIL burst_in_burst_gap: got %0d want 3", obs_t[1] - obs_t[0]); end
            vectors++; if (obs_t[4] - obs_t[3] != 4) begin errors++; $display("FAIL burst_regrant_gap: got %0d want 4", obs_t[4] - obs_t[3]); end
        end
        arb_en = 1'b0;
    endtask

    task automatic test_backpressure();
        bit seen, ok;
        do_reset();
        load(1, 8'h11);
        load(1, 8'h12);
        arb_en = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step(1);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        vectors++; if (!seen || out_data !== 8'h11 || out_port !== 2'd1) begin
            errors++; $display("FAIL bp_first: seen=%b data=%h port=%0d want 1/11/1", seen, out_data, out_port); end
        for (int c = 0; c < 5; c++) begin
            step(1);
            vectors++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_port !== 2'd1 || port_rd !== 4'b0000) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b data=%h port=%0d rd=%b want 1/11/1/0000", c, out_valid, out_data, out_port, port_rd); end
        end
        out_ready = 1'b1;
        step(1);
        vectors++; if (obs_q.size() != 1 || obs_q[0] !== {2'd1, 8'h11}) begin
            errors++; $display("FAIL bp_release: words=%0d want 1 of 111", obs_q.size()); end
        wait_obs(2, 30, ok);
        step(10);
        vectors++; if (obs_q.size() != 2 || obs_q[1] !== {2'd1, 8'h12}) begin
            errors++; $display("FAIL bp_second: words=%0d want 2 ending 112", obs_q.size()); end
        vectors++; if (rd_cnt[1] != 2) begin errors++; $display("FAIL bp_rd_count: got %0d want 2", rd_cnt[1]); end
    endtask

    task automatic test_short_burst();
        bit ok;
        do_reset();
        load(2, 8'h21);
        load(2, 8'h22);
        load(3, 8'h31);
        arb_en = 1'b1; out_ready = 1'b1;
        wait_obs(3, 60, ok);
        step(10);
        vectors++; if (!ok || obs_q.size() != 3) begin errors++; $display("FAIL short_count: got %0d words want 3", obs_q.size()); end
        else begin
            vectors++; if (obs_q[0] !== {2'd2, 8'h21} || obs_q[1] !== {2'd2, 8'h22}) begin
                errors++; $display("FAIL short_port2: got %h %h want 221 222", obs_q[0], obs_q[1]); end
            vectors++; if (obs_q[2] !== {2'd3, 8'h31}) begin errors++; $display("FAIL short_next: got %h want 331", obs_q[2]); end
        end
        vectors++; if (rd_cnt[2] != 2 || rd_cnt[3] != 1) begin
            errors++; $display("FAIL short_rd_count: got %0d/%0d want 2/1", rd_cnt[2], rd_cnt[3]); end
    endtask

    task automatic test_async_reset();
        bit seen, ok;
        do_reset();
        load(1, 8'h11);
        load(1, 8'h12);
        load(3, 8'h31);
        arb_en = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step(1);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        vectors++; if (!seen) begin errors++; $display("FAIL areset_send: out_valid got 0 want 1"); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || out_port !== 2'd0) begin
            errors++; $display("FAIL areset_async: valid=%b data=%h busy=%b port=%0d want 0/00/0/0", out_valid, out_data, busy, out_port); end
        step(1);
        vectors++; if (port_rd !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL areset_held: rd=%b busy=%b want 0000/0", port_rd, busy); end
        rst_n = 1'b1; out_ready = 1'b1;
        wait_obs(2, 60, ok);
        vectors++; if (!ok || obs_q[0] !== {2'd1, 8'h12} || obs_q[1] !== {2'd3, 8'h31}) begin
            errors++; $display("FAIL areset_regrant: words=%0d first=%h want 112 then 331", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h0); end
    endtask

    task automatic test_arb_en_drop();
        bit seen, ok;
        do_reset();
        load(0, 8'h01);
        load(0, 8'h02);
        load(0, 8'h03);
        arb_en = 1'b1; out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step(1);
            if (port_rd === 4'b0001) seen = 1'b1;
        end
        vectors++; if (!seen) begin errors++; $display("FAIL drop_first_read: port_rd never 0001"); end
        step(1);
        arb_en = 1'b0;
        step(1);
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin
            errors++; $display("FAIL drop_word_kept: valid=%b data=%h want 1/01", out_valid, out_data); end
        step(1);
        vectors++; if (obs_q.size() != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL drop_to_idle: words=%0d busy=%b want 1/0", obs_q.size(), busy); end
        step(10);
        vectors++; if (rd_cnt[0] != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL drop_no_reads: reads=%0d busy=%b want 1/0", rd_cnt[0], busy); end
        arb_en = 1'b1;
        wait_obs(3, 40, ok);
        vectors++; if (!ok || obs_q[1] !== {2'd0, 8'h02} || obs_q[2] !== {2'd0, 8'h03}) begin
            errors++; $display("FAIL drop_resume: words=%0d want 002 then 003", obs_q.size()); end
    endtask

    task automatic test_port_rd_hygiene();
        vectors++; if (rd_multi_seen !== 1'b0) begin errors++; $display("FAIL rd_onehot: multi-bit strobe seen=%b want 0", rd_multi_seen); end
        vectors++; if (rd_empty_seen !== 1'b0) begin errors++; $display("FAIL rd_empty: read of empty port seen=%b want 0", rd_empty_seen); end
    endtask

    initial begin
        rst_n = 1'b0; arb_en = 1'b0; out_ready = 1'b0;
        test_reset();
        test_single_word();
        test_burst_rotation();
        test_backpressure();
        test_short_burst();
        test_async_reset();
        test_arb_en_drop();
        test_port_rd_hygiene();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
